hvac_zone_scheduler: RTL and testbench

Shares a single heating/cooling plant among NZ thermostat zones. Each zone raises a heat or cool request (the heat_o/cool_o of a per-zone thermostat FSM). The scheduler grants one zone at a time in round-robin order and drives the plant.
- Enforces a minimum run time (compressor anti-short-cycle).
- Enforces a maximum run time when other zones are waiting (fairness).
- Inserts a fixed dead time between any two grants.

---
 rtl/hvac_pkg.sv | 28 ++
 rtl/rr_picker.sv | 41 ++++
 rtl/hvac_zone_scheduler.sv | 135 +++++++++++++
 tb/tb_hvac_zone_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// Shared types for the HVAC plant scheduler and the per-zone thermostat FSM.
//   sched_state_t : scheduler state, one-hot encoded
//   plant_mode_t  : what the shared plant is doing
//   mode_of()     : plant mode implied by a scheduler state
package hvac_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    RUN_HEAT = 4'b0010,
    RUN_COOL = 4'b0100,
    DEAD     = 4'b1000
  } sched_state_t;

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_HEAT,
    MODE_COOL
  } plant_mode_t;

  function automatic plant_mode_t mode_of(input sched_state_t s);
    case (s)
      RUN_HEAT: return MODE_HEAT;
      RUN_COOL: return MODE_COOL;
      default:  return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker (combinational).
//   req_i    : request vector, one bit per zone
//   ptr_i    : zone index where the search starts
//   any_o    : at least one request present
//   idx_o    : first requesting zone at or above ptr_i, wrapping NZ-1 -> 0
//   onehot_o : idx_o as a one-hot vector (zero when any_o=0)
module rr_picker #(
  parameter int NZ = 4
) (
  input  logic [NZ-1:0]         req_i,
  input  logic [$clog2(NZ)-1:0] ptr_i,
  output logic                  any_o,
  output logic [$clog2(NZ)-1:0] idx_o,
  output logic [NZ-1:0]         onehot_o
);

  localparam int PW = $clog2(NZ);
  localparam int FW = $clog2(2*NZ);

  logic [2*NZ-1:0] w_dbl;
  logic [FW-1:0]   w_pos;

  // Doubling the vector turns the wrap-around search into a plain
  // lowest-set-bit search: the lower copy is masked below ptr_i, the
  // upper copy supplies the wrapped zones.
  always_comb begin
    w_dbl = {req_i, req_i} & ({(2*NZ){1'b1}} << ptr_i);
    w_pos = '0;
    for (int i = 2*NZ-1; i >= 0; i--)
      if (w_dbl[i]) w_pos = FW'(i);
  end

  assign any_o = |req_i;
  assign idx_o = (w_pos >= FW'(NZ)) ? PW'(w_pos - FW'(NZ)) : PW'(w_pos);

  always_comb begin
    onehot_o = '0;
    if (any_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Shares one heating/cooling plant among NZ zones, one grant at a time,
// round-robin, with minimum run time, fairness pre-emption after MAX_ON
// and a fixed plant-off gap of DEAD cycles between grants.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   heat_req_i     : per-zone heat request (level)
//   cool_req_i     : per-zone cool request (level)
//   heat_o, cool_o : plant heater / cooler on
//   grant_o        : one-hot granted zone valve, zero when plant is off
//   busy_o         : scheduler not idle
//   conflict_o     : zones that asserted heat and cool together last cycle
// DEAD is assumed <= MAX_ON so the shared run/dead counter is wide enough.
module hvac_zone_scheduler import hvac_pkg::*; #(
  parameter int NZ     = 4,
  parameter int MIN_ON = 8,
  parameter int MAX_ON = 32,
  parameter int DEAD   = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [NZ-1:0] heat_req_i,
  input  logic [NZ-1:0] cool_req_i,
  output logic          heat_o,
  output logic          cool_o,
  output logic [NZ-1:0] grant_o,
  output logic          busy_o,
  output logic [NZ-1:0] conflict_o
);

  localparam int CW = $clog2(MAX_ON+1);
  localparam int PW = $clog2(NZ);
  localparam logic [CW-1:0] C_MIN  = CW'(MIN_ON);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_ON);
  localparam logic [CW-1:0] C_DEAD = CW'(DEAD);

  sched_state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [NZ-1:0] r_grant, w_grant_nxt;
  logic [NZ-1:0] r_conflict;
  logic          r_heat, r_cool, r_busy;

  logic [NZ-1:0] w_valid, w_onehot;
  logic [PW-1:0] w_idx;
  logic          w_any, w_drop, w_other, w_leave;
  plant_mode_t   w_mode;

  // Zones asking for both modes are not serviceable.
  assign w_valid = heat_req_i ^ cool_req_i;

  rr_picker #(.NZ(NZ)) u_pick (
    .req_i    (w_valid),
    .ptr_i    (r_ptr),
    .any_o    (w_any),
    .idx_o    (w_idx),
    .onehot_o (w_onehot)
  );

  // Drop: granted zone no longer wants the running mode, or is in conflict.
  assign w_drop  = ((r_state == RUN_HEAT) ? ~|(r_grant & heat_req_i)
                                          : ~|(r_grant & cool_req_i))
                 | |(r_grant & heat_req_i & cool_req_i);
  assign w_other = |(w_valid & ~r_grant);
  assign w_leave = ((r_cnt >= C_MIN) && w_drop) || ((r_cnt >= C_MAX) && w_other);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = heat_req_i[w_idx] ? RUN_HEAT : RUN_COOL;
          w_grant_nxt = w_onehot;
          w_cnt_nxt   = CW'(1);
          w_ptr_nxt   = (w_idx == PW'(NZ-1)) ? '0 : w_idx + 1'b1;
        end
      end
      RUN_HEAT, RUN_COOL: begin
        if (w_leave) begin
          w_state_nxt = hvac_pkg::DEAD;
          w_grant_nxt = '0;
          w_cnt_nxt   = CW'(1);
        end else if (r_cnt < C_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      hvac_pkg::DEAD: begin
        // Counter runs 1..DEAD across the dead phase.
        if (r_cnt >= C_DEAD) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_mode = mode_of(w_state_nxt);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_conflict <= '0;
      r_heat     <= 1'b0;
      r_cool     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_conflict <= heat_req_i & cool_req_i;
      r_heat     <= (w_mode == MODE_HEAT);
      r_cool     <= (w_mode == MODE_COOL);
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign heat_o     = r_heat;
  assign cool_o     = r_cool;
  assign grant_o    = r_grant;
  assign busy_o     = r_busy;
  assign conflict_o = r_conflict;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
module tb_hvac_zone_scheduler;

  localparam int NZ = 4, MIN_ON = 8, MAX_ON = 32, DEAD = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_DEAD = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [NZ-1:0] heat_req_i = '0;
  logic [NZ-1:0] cool_req_i = '0;
  logic          heat_o, cool_o, busy_o;
  logic [NZ-1:0] grant_o, conflict_o;

  always #5 clk_i = ~clk_i;

  hvac_zone_scheduler #(.NZ(NZ), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .DEAD(DEAD)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .heat_req_i (heat_req_i),
    .cool_req_i (cool_req_i),
    .heat_o     (heat_o),
    .cool_o     (cool_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .conflict_o (conflict_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: phase of the plant, which zone holds it, in which mode,
  // how long it has run, how many off cycles remain, and where the search starts.
  int            m_phase, m_zone, m_run, m_dead_left, m_ptr;
  bit            m_heat;
  logic [NZ-1:0] m_conf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit found, drop, other;
    if (!rst_ni) begin
      m_phase = P_IDLE; m_ptr = 0; m_run = 0; m_dead_left = 0; m_zone = 0;
      m_heat = 0; m_conf = '0;
      return;
    end
    m_conf = heat_req_i & cool_req_i;
    case (m_phase)
      P_IDLE: begin
        found = 0;
        for (int j = 0; j < NZ; j++) begin
          int k;
          k = (m_ptr + j) % NZ;
          if (!found && (heat_req_i[k] != cool_req_i[k])) begin
            found   = 1;
            m_zone  = k;
            m_heat  = heat_req_i[k];
            m_run   = 1;
            m_phase = P_RUN;
          end
        end
        if (found) m_ptr = (m_zone + 1) % NZ;
      end
      P_RUN: begin
        drop = (m_heat ? !heat_req_i[m_zone] : !cool_req_i[m_zone])
               || (heat_req_i[m_zone] && cool_req_i[m_zone]);
        other = 0;
        for (int z = 0; z < NZ; z++)
          if (z != m_zone && heat_req_i[z] != cool_req_i[z]) other = 1;
        if ((m_run >= MIN_ON && drop) || (m_run >= MAX_ON && other)) begin
          m_phase     = P_DEAD;
          m_dead_left = DEAD;
        end else if (m_run < MAX_ON) begin
          m_run++;
        end
      end
      default: begin
        m_dead_left--;
        if (m_dead_left == 0) m_phase = P_IDLE;
      end
    endcase
  endtask

  // One clock: model consumes the inputs the DUT sees at this edge, then
  // every output is compared #1 later.
  task automatic tick();
    logic [NZ-1:0] e_grant;
    @(posedge clk_i);
    model_step();
    #1;
    e_grant = '0;
    if (m_phase == P_RUN) e_grant[m_zone] = 1'b1;
    chk("heat_o",     heat_o,     (m_phase == P_RUN) && m_heat);
    chk("cool_o",     cool_o,     (m_phase == P_RUN) && !m_heat);
    chk("grant_o",    grant_o,    e_grant);
    chk("busy_o",     busy_o,     m_phase != P_IDLE);
    chk("conflict_o", conflict_o, m_conf);
  endtask

  initial begin
    int n_on, n_z3;

    // Reset with every request high.
    heat_req_i = '1; cool_req_i = '1; rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1; heat_req_i = '0; cool_req_i = '0;
    tick();

    // One-cycle heat pulse on zone 2 -> MIN_ON on-cycles, DEAD off, idle.
    heat_req_i = 4'b0100;
    tick();
    chk("t2_grant_first", grant_o, 4'b0100);
    n_on = heat_o;
    heat_req_i = '0;
    repeat (15) begin tick(); n_on += heat_o; end
    chk("t2_on_cycles", n_on, MIN_ON);
    chk("t2_idle_after", busy_o, 0);

    // Zones 0 and 1 held: MAX_ON pre-emption and wrap-around.
    heat_req_i = 4'b0011;
    repeat (2*(MAX_ON + DEAD + 1) + 3) tick();
    chk("t3_wrapped_to_z0", grant_o, 4'b0001);
    heat_req_i = '0;
    repeat (MIN_ON + DEAD + 2) tick();

    // Zone 3 in conflict, zone 1 cooling.
    heat_req_i = 4'b1000; cool_req_i = 4'b1010;
    n_z3 = 0;
    repeat (20) begin tick(); n_z3 += grant_o[3]; end
    chk("t4_z3_never_granted", n_z3, 0);
    heat_req_i = '0; cool_req_i = '0;
    repeat (MIN_ON + DEAD + 2) tick();

    // Zone 0 heat switches to cool at run cycle 3.
    heat_req_i = 4'b0001;
    repeat (3) tick();
    heat_req_i = '0; cool_req_i = 4'b0001;
    repeat (MIN_ON - 3 + DEAD + 1 + 2) tick();
    chk("t5_cool_z0", {cool_o, grant_o}, {1'b1, 4'b0001});
    cool_req_i = '0;
    repeat (MIN_ON + DEAD + 2) tick();

    // Reset mid-run with pointer advanced; zone 0 wins afterwards.
    cool_req_i = 4'b0010;
    tick();
    heat_req_i = 4'b0101;
    repeat (4) tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("t6_z0_after_reset", grant_o, 4'b0001);
    heat_req_i = '0; cool_req_i = '0;
    repeat (MIN_ON + DEAD + 2) tick();

    // Random request traffic with slowly varying levels and rare resets.
    for (int c = 0; c < 2500; c++) begin
      for (int z = 0; z < NZ; z++) begin
        if ($urandom_range(0, 11) == 0) heat_req_i[z] = ~heat_req_i[z];
        if ($urandom_range(0, 11) == 0) cool_req_i[z] = ~cool_req_i[z];
      end
      rst_ni = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
